// File: rtl/aes128_decrypt_engine.sv
// Iterative AES-128 inverse cipher, one round per clock, walking a key/ciphertext ROM.
// Optional KEY_CACHE_EN skips key expansion when the next block reuses the previous key.
module aes128_decrypt_engine #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BLOCKS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [127:0]          cyphertext_i,
    input  logic [127:0]          key_i,
    output logic [127:0]          m3_reg_o,
    output logic                  finish_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    typedef enum logic [2:0] {
        KLOAD, KEXP, ARK, ROUND, FINAL, DONE, HALT
    } fsm_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_BLOCKS - 1);

    fsm_t                  fsm, fsm_next;
    logic [127:0]          st;
    logic [127:0]          rk [0:10];
    logic [3:0]            rnd;
    logic [ADDR_WIDTH-1:0] pc;
`ifdef KEY_CACHE_EN
    logic                  valid;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = ginv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]}
                 ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] x;
        x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return ginv(x);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte 4c+r sits at bits 127-8*(4c+r); row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                             ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                             ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                             ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                             ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] v;
        case (i)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rcon(i), 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // State register for the block sequencer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fsm <= KLOAD;
        else         fsm <= fsm_next;
    end

    // Next-state selection; the last block parks the engine in HALT.
    always_comb begin
        fsm_next = fsm;
        unique case (fsm)
`ifdef KEY_CACHE_EN
            KLOAD: fsm_next = (valid && key_i == rk[0]) ? ARK : KEXP;
`else
            KLOAD: fsm_next = KEXP;
`endif
            KEXP:  if (rnd == 4'd10) fsm_next = ARK;
            ARK:   fsm_next = ROUND;
            ROUND: if (rnd == 4'd1) fsm_next = FINAL;
            FINAL: fsm_next = DONE;
            DONE:  fsm_next = (pc == LAST) ? HALT : KLOAD;
            HALT:  fsm_next = HALT;
            default: fsm_next = KLOAD;
        endcase
    end

    // Key schedule, round datapath, block address and finish pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st       <= '0;
            rnd      <= '0;
            pc       <= '0;
            finish_o <= 1'b0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
`ifdef KEY_CACHE_EN
            valid    <= 1'b0;
`endif
        end else begin
            finish_o <= (fsm == FINAL);
            unique case (fsm)
                KLOAD: begin
                    rk[0] <= key_i;
                    rnd   <= 4'd1;
                end
                KEXP: begin
                    rk[rnd] <= key_expand(rk[rnd - 4'd1], rnd);
                    rnd     <= rnd + 4'd1;
`ifdef KEY_CACHE_EN
                    if (rnd == 4'd10) valid <= 1'b1;
`endif
                end
                ARK: begin
                    st  <= cyphertext_i ^ rk[10];
                    rnd <= 4'd9;
                end
                ROUND: begin
                    st  <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(st)) ^ rk[rnd]);
                    rnd <= rnd - 4'd1;
                end
                FINAL: st <= inv_sub_bytes(inv_shift_rows(st)) ^ rk[0];
                DONE:  if (pc != LAST) pc <= pc + 1'b1;
                HALT:  ;
                default: ;
            endcase
        end
    end

    assign m3_reg_o = st;
    assign pc_o     = pc;

endmodule

// File: tb/tb_aes128_decrypt_engine.sv
// Bench for aes128_decrypt_engine: ROM model, scoreboard of expected plaintexts.
// Honours KEY_CACHE_EN for key layout and expected latencies.
module tb_aes128_decrypt_engine;

    localparam int AW = 5;
    localparam int NB = 4;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        int           pc;
        logic [127:0] pt;
        int           cyc;
    } exp_t;

    logic          clk;
    logic          rst_ni;
    logic [127:0]  ct;
    logic [127:0]  key;
    logic [127:0]  m3;
    logic          finish;
    logic [AW-1:0] pc;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   pulses;
    logic prev_fin;

    aes128_decrypt_engine #(
        .ADDR_WIDTH(AW),
        .NUM_BLOCKS(NB)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .cyphertext_i(ct),
        .key_i(key),
        .m3_reg_o(m3),
        .finish_o(finish),
        .pc_o(pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Which test vector lives at a given ROM address.
    function automatic bit is_a(input int p);
`ifdef KEY_CACHE_EN
        return p < 2;
`else
        return (p % 2) == 0;
`endif
    endfunction

    function automatic int lat(input int p);
`ifdef KEY_CACHE_EN
        return (p % 2 == 1) ? 13 : 23;
`else
        return 23;
`endif
    endfunction

    // Ciphertext/key ROM addressed by pc_o.
    always_comb begin
        ct  = CB;
        key = KB;
        if (is_a(int'(pc))) begin
            ct  = CA;
            key = KA;
        end
    end

    // Watch for back-to-back finish pulses and count pulses since reset.
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_fin = 1'b0;
            pulses   = 0;
        end else begin
            checks++;
            assert (!(finish === 1'b1 && prev_fin === 1'b1)) else begin
                errors++;
                $error("FAIL finish_twice got 11 exp not both high at cyc %0d", cyc);
            end
            if (finish === 1'b1) pulses++;
            prev_fin = finish;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push_blocks(input int n);
        int t;
        exp_t e;
        t = 0;
        for (int b = 0; b < n; b++) begin
            t     += lat(b);
            e.pc  = b;
            e.pt  = is_a(b) ? PA : PB;
            e.cyc = t;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_finish(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (finish === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Pop one scoreboard entry and compare it to the next finish pulse.
    task automatic pop_and_check();
        exp_t e;
        bit   ok;
        e = sb.pop_front();
        wait_finish(60, ok);
        chk($sformatf("blk%0d_seen", e.pc), 128'(ok), 128'(1));
        chk($sformatf("blk%0d_pc", e.pc), 128'(pc), 128'(e.pc));
        chk($sformatf("blk%0d_pt", e.pc), m3, e.pt);
        chk($sformatf("blk%0d_cyc", e.pc), 128'(cyc), 128'(e.cyc));
        step();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", 128'(pc), 128'(0));
        chk("rst_m3", m3, 128'(0));
        chk("rst_fin", 128'(finish), 128'(0));
        rst_ni = 1'b1;
        cyc    = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_ni = 1'b0;

        do_reset();
        sb.delete();
        push_blocks(NB);
        for (int b = 0; b < NB; b++) pop_and_check();

        while (cyc < 200) begin
            chk("halt_pc", 128'(pc), 128'(NB - 1));
            chk("halt_fin", 128'(finish), 128'(0));
            step();
        end
        chk("halt_m3", m3, PB);
        chk("pulses", 128'(pulses), 128'(NB));

        do_reset();
        sb.delete();
        push_blocks(2);
        pop_and_check();
        pop_and_check();
        repeat (13) step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_pc", 128'(pc), 128'(0));
        chk("async_m3", m3, 128'(0));
        chk("async_fin", 128'(finish), 128'(0));

        do_reset();
        sb.delete();
        push_blocks(2);
        pop_and_check();
        pop_and_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_engine.md
Name: aes128_decrypt_engine

Overview:
- Iterative AES-128 decryption engine (FIPS-197 inverse cipher), one round per clock.
- Drives a block address (pc_o) into an external ciphertext/key ROM.
- Reads ciphertext_i and key_i, expands the key, and decrypts.
- Presents the plaintext on m3_reg_o with a one-cycle finish_o pulse; an external plaintext RAM writes m3_reg_o at address pc_o when finish_o is high. Then the engine advances to the next block.

Parameters:
- ADDR_WIDTH, 5, width of pc_o.
- NUM_BLOCKS, 16, number of blocks to process (pc 0..NUM_BLOCKS-1); must be ≤ 2**ADDR_WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- cyphertext_i  input  128  ciphertext block at address pc_o; bit 127 = byte 0 (FIPS byte order, big-endian).
- key_i  input  128  cipher key at address pc_o; same byte order.
- m3_reg_o  output  128  state register; holds the plaintext during the finish_o cycle.
- finish_o  output  1  one-cycle pulse, plaintext valid.
- pc_o  output  ADDR_WIDTH  current block address.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - pc_o=0, m3_reg_o=0, finish_o=0, round counter=0.
  - Round-key file cleared.
  - FSM goes to KLOAD.
  - Reset mid-block aborts the block with no write.
- FSM states, one clock each unless noted:
  - KLOAD: rk[0]<=key_i; go to KEXP.
  - KEXP (10 cycles, i=1..10): rk[i]<=KeyExpand(rk[i-1], Rcon[i]).
    - Rcon = 01,02,04,08,10,20,40,80,1b,36.
    - Standard RotWord/SubWord/XOR chain.
  - ARK: state<=cyphertext_i ^ rk[10]; r<=9.
  - ROUND (9 cycles, r=9..1): state<=InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]); r decrements.
  - FINAL: state<=InvSubBytes(InvShiftRows(state)) ^ rk[0].
  - DONE: finish_o=1 (registered, high exactly this cycle); m3_reg_o=plaintext; pc_o unchanged.
    - If pc_o==NUM_BLOCKS-1, go to HALT.
    - Otherwise pc_o<=pc_o+1 and go to KLOAD.
  - HALT: terminal; finish_o=0; pc_o and m3_reg_o hold until reset.
- Latency:
  - 23 cycles per block from entering KLOAD to the end of DONE.
  - First finish_o is in the 23rd cycle after reset deassertion.
- The key is re-expanded for every block, since key_i may differ per address.
- cyphertext_i is sampled only in ARK.
- key_i is sampled only in KLOAD.
- pc_o is stable for the whole block.
- m3_reg_o always reflects the state register, including intermediate round values. Only the DONE cycle is valid plaintext.
- InvSubBytes uses the FIPS-197 inverse S-box; SubWord uses the forward S-box. Either a table or GF(2^8)-inverse logic is acceptable.
- InvMixColumns multiplies each column by the matrix {0e,0b,0d,09} over GF(2^8), polynomial 0x11b.
- InvShiftRows rotates row r right by r bytes (column-major state layout).

Optional Feature:
- Macro: KEY_CACHE_EN.
- When defined:
  - A valid flag is cleared by reset.
  - In KLOAD, if valid=1 and key_i==rk[0], the FSM goes directly to ARK, skipping KEXP. Per-block latency becomes 13 cycles.
  - Otherwise full expansion runs, and valid is set at the end of KEXP.
- When undefined: expansion always runs (23 cycles per block), and no cache logic is present.

Test Plan:
- Block 0: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> finish_o in cycle 23 after reset, m3_reg_o=00112233445566778899aabbccddeeff, pc_o=0.
- Block 1: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> m3_reg_o=3243f6a8885a308d313198a2e0370734 at pc_o=1, cycle 46 (without KEY_CACHE_EN).
- NUM_BLOCKS=4, run 200 cycles -> exactly 4 finish_o pulses at pc 0..3, then HALT with pc_o=3 and finish_o=0.
- Reset asserted during ROUND of block 2 -> pc_o=0, m3_reg_o=0, finish_o=0 immediately (asynchronously); after release, decryption restarts at block 0 with correct results.
- KEY_CACHE_EN with identical keys at pc 0 and 1 -> second finish_o 13 cycles after the first; a different key at pc 2 -> 23 cycles.
- Check finish_o is never high for two consecutive cycles, and m3_reg_o matches the expected plaintext only when finish_o=1.
